arty7_gpio_debounce: RTL

Board-input conditioning stage for the Arty-7 top wrapper. It sits between the raw FPGA pins (slide switches and push-buttons) and the SoC `gpio_i[19:16]` inputs. It synchronises each asynchronous pin into `clk_i` and suppresses contact bounce with a per-channel stability counter. It also optionally emits one-cycle edge pulses for software-free event detection.

---
 rtl/arty7_pkg.sv | 16 +
 rtl/arty7_dbnc_chan.sv | 73 +++++++
 rtl/arty7_gpio_debounce.sv | 48 ++++
 3 files changed

// File: rtl/arty7_pkg.sv
// Board-level constants for the Arty-7 input conditioning stage, plus the
// per-channel result bundle shared by the debounce top and its channel module.
package arty7_pkg;

    localparam int unsigned ClkFreqHz         = 100_000_000;
    localparam int unsigned DbncMs            = 10;
    localparam int unsigned DbncCyclesDefault = (ClkFreqHz / 1000) * DbncMs;
    localparam int unsigned NumBoardGpio      = 4;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } dbnc_out_t;

endpackage

// File: rtl/arty7_dbnc_chan.sv
// One debounce channel: input synchroniser, stability counter, stable level
// and (with ARTY7_DBNC_EDGE_EN defined) registered rise/fall pulses.
import arty7_pkg::*;

module arty7_dbnc_chan #(
    parameter int SyncStages = 2,
    parameter int DbncCycles = 4,
    parameter int CntW       = 20
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      pin_i,
    output dbnc_out_t chan_o
);

    localparam logic [CntW-1:0] CntMax = CntW'(DbncCycles - 1);

    logic [SyncStages-1:0] sync_reg;
    logic [CntW-1:0]       cnt_reg;
    logic                  stable_reg;
    logic                  sync;
    logic                  accept;

    assign sync   = sync_reg[SyncStages-1];
    // The new level is taken on the DbncCycles-th consecutive disagreeing cycle.
    assign accept = (sync != stable_reg) && (cnt_reg == CntMax);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SyncStages-2:0], pin_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
        end else if (sync == stable_reg) begin
            cnt_reg <= '0;
        end else if (accept) begin
            stable_reg <= sync;
            cnt_reg    <= '0;
        end else begin
            cnt_reg <= cnt_reg + CntW'(1);
        end
    end

`ifdef ARTY7_DBNC_EDGE_EN
    logic rise_reg;
    logic fall_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            rise_reg <= accept & sync;
            fall_reg <= accept & ~sync;
        end
    end

    assign chan_o.rise = rise_reg;
    assign chan_o.fall = fall_reg;
`else
    assign chan_o.rise = 1'b0;
    assign chan_o.fall = 1'b0;
`endif

    assign chan_o.level = stable_reg;

endmodule

// File: rtl/arty7_gpio_debounce.sv
// Arty-7 slide-switch / push-button conditioning: NumCh independent debounce
// channels. Define ARTY7_DBNC_EDGE_EN to enable the rise_o/fall_o pulses.
import arty7_pkg::*;

module arty7_gpio_debounce #(
    parameter int NumCh      = int'(NumBoardGpio),
    parameter int SyncStages = 2,
    parameter int DbncCycles = int'(DbncCyclesDefault),
    parameter int CntW       = 20
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NumCh-1:0] pin_i,
    output logic [NumCh-1:0] gpio_o,
    output logic [NumCh-1:0] rise_o,
    output logic [NumCh-1:0] fall_o
);

    if (SyncStages < 2) begin : g_bad_sync
        $error("arty7_gpio_debounce: SyncStages must be >= 2");
    end
    if (DbncCycles < 1) begin : g_bad_dbnc
        $error("arty7_gpio_debounce: DbncCycles must be >= 1");
    end
    if ((DbncCycles - 1) >= (2 ** CntW)) begin : g_bad_cntw
        $error("arty7_gpio_debounce: CntW too narrow for DbncCycles");
    end

    dbnc_out_t chan_out [NumCh];

    for (genvar gi = 0; gi < NumCh; gi++) begin : g_chan
        arty7_dbnc_chan #(
            .SyncStages (SyncStages),
            .DbncCycles (DbncCycles),
            .CntW       (CntW)
        ) u_chan (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .pin_i  (pin_i[gi]),
            .chan_o (chan_out[gi])
        );

        assign gpio_o[gi] = chan_out[gi].level;
        assign rise_o[gi] = chan_out[gi].rise;
        assign fall_o[gi] = chan_out[gi].fall;
    end

endmodule
